// File: rtl/present_core.sv
// present_core: iterative PRESENT block cipher, one round per clock.
// 80- or 128-bit key chosen at elaboration; encrypt or decrypt chosen per operation.
// Decrypt first runs the key schedule forward (KEYGEN), then walks it backwards (DEC).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      launch an operation, accepted only while ready=1
//   decrypt    0 = encrypt, 1 = decrypt, sampled with start
//   master_key cipher key, sampled with start
//   plain_text data in (plaintext or ciphertext), sampled with start
//   out        registered result
//   ended      result valid, held until the next accepted start
//   ready      core idle, start will be accepted
module present_core #(
    parameter int unsigned KEY_W  = 80,
    parameter int unsigned ROUNDS = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             decrypt,
    input  logic [KEY_W-1:0] master_key,
    input  logic [63:0]      plain_text,
    output logic [63:0]      out,
    output logic             ended,
    output logic             ready
);

    if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
        $error("present_core: KEY_W must be 80 or 128");
    end
    if (ROUNDS == 0 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_core: ROUNDS must be in 1..31");
    end

    // Bit position of the round-counter XOR inside the key register.
    localparam int unsigned RcLsb  = (KEY_W == 80) ? 15 : 62;
    localparam logic [4:0]  LastRc = 5'(ROUNDS);

    // Nibble x of each table holds S(x) / S^-1(x).
    localparam logic [63:0] SboxTab    = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] InvSboxTab = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [1:0] {StIdle, StKeygen, StEnc, StDec} state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SboxTab[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return InvSboxTab[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox(x[4*n +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 63; i++) r[(16 * i) % 63] = x[i];
        r[63] = x[63];
        return r;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 63; i++) r[i] = x[(16 * i) % 63];
        r[63] = x[63];
        return r;
    endfunction

    // Forward key schedule step: rotate left 61, S-box the top nibble(s), mix in rc.
    function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                                 input logic [4:0]       rc);
        logic [KEY_W-1:0] r;
        r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
        r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
        if (KEY_W == 128) r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
        r[RcLsb +: 5] = r[RcLsb +: 5] ^ rc;
        return r;
    endfunction

    // Exact inverse of key_fwd for the same rc.
    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                                 input logic [4:0]       rc);
        logic [KEY_W-1:0] r;
        r = k;
        r[RcLsb +: 5] = r[RcLsb +: 5] ^ rc;
        r[KEY_W-1 -: 4] = inv_sbox(r[KEY_W-1 -: 4]);
        if (KEY_W == 128) r[KEY_W-5 -: 4] = inv_sbox(r[KEY_W-5 -: 4]);
        return {r[60:0], r[KEY_W-1:61]};
    endfunction

    state_e           st_q;
    logic [63:0]      data_q;
    logic [KEY_W-1:0] key_q;
    logic [4:0]       rc_q;
    logic [63:0]      out_q;
    logic             ended_q;
    logic             ready_q;

    logic [63:0]      rk;
    logic [KEY_W-1:0] key_next;
    logic [KEY_W-1:0] key_prev;
    logic [63:0]      enc_state;
    logic [63:0]      dec_state;

    always_comb begin
        rk        = key_q[KEY_W-1 -: 64];
        key_next  = key_fwd(key_q, rc_q);
        key_prev  = key_inv(key_q, rc_q);
        enc_state = p_layer(s_layer(data_q ^ rk));
        dec_state = inv_s_layer(inv_p_layer(data_q)) ^ key_prev[KEY_W-1 -: 64];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            data_q  <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            out_q   <= '0;
            ended_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (st_q)
                StIdle: begin
                    if (start) begin
                        data_q  <= plain_text;
                        key_q   <= master_key;
                        rc_q    <= 5'd1;
                        ended_q <= 1'b0;
                        ready_q <= 1'b0;
                        st_q    <= decrypt ? StKeygen : StEnc;
                    end
                end
                StEnc: begin
                    data_q <= enc_state;
                    key_q  <= key_next;
                    rc_q   <= rc_q + 5'd1;
                    if (rc_q == LastRc) begin
                        // Final whitening with the last round key.
                        out_q   <= enc_state ^ key_next[KEY_W-1 -: 64];
                        ended_q <= 1'b1;
                        ready_q <= 1'b1;
                        st_q    <= StIdle;
                    end
                end
                StKeygen: begin
                    key_q <= key_next;
                    if (rc_q == LastRc) begin
                        // Undo the final whitening; rc stays at the last round for DEC.
                        data_q <= data_q ^ key_next[KEY_W-1 -: 64];
                        st_q   <= StDec;
                    end else begin
                        rc_q <= rc_q + 5'd1;
                    end
                end
                StDec: begin
                    key_q  <= key_prev;
                    data_q <= dec_state;
                    rc_q   <= rc_q - 5'd1;
                    if (rc_q == 5'd1) begin
                        out_q   <= dec_state;
                        ended_q <= 1'b1;
                        ready_q <= 1'b1;
                        st_q    <= StIdle;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign out   = out_q;
    assign ended = ended_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_present_core.sv
`timescale 1ns/1ps
module tb_present_core;
    localparam int ROUNDS = 31;
    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    localparam logic [127:0] K80_ONES = {48'h0, {80{1'b1}}};
    localparam logic [63:0]  ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        int          d;
        logic [63:0] exp;
        longint      end_cyc;
        bit          held;
        string       name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_s [2];
    logic         dec_s   [2];
    logic [127:0] key_s   [2];
    logic [63:0]  pt_s    [2];
    logic [63:0]  out_s   [2];
    logic         ended_s [2];
    logic         ready_s [2];

    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    exp_t   sb[$];

    present_core #(.KEY_W(80), .ROUNDS(ROUNDS)) dut80 (
        .clk(clk), .rst(rst), .start(start_s[0]), .decrypt(dec_s[0]),
        .master_key(key_s[0][79:0]), .plain_text(pt_s[0]),
        .out(out_s[0]), .ended(ended_s[0]), .ready(ready_s[0])
    );

    present_core #(.KEY_W(128), .ROUNDS(ROUNDS)) dut128 (
        .clk(clk), .rst(rst), .start(start_s[1]), .decrypt(dec_s[1]),
        .master_key(key_s[1]), .plain_text(pt_s[1]),
        .out(out_s[1]), .ended(ended_s[1]), .ready(ready_s[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog");
    end

    // Reference PRESENT: build the full round-key list, then apply it forwards or backwards.
    function automatic logic [63:0] ref_cipher(input logic [127:0] key, input int kw,
                                               input logic [63:0] din, input bit dec);
        logic [127:0] k, nk;
        logic [63:0]  rk [ROUNDS+1];
        logic [63:0]  s, t;
        int           lsb;
        lsb = (kw == 80) ? 15 : 62;
        k = key;
        for (int r = 1; r <= ROUNDS + 1; r++) begin
            for (int b = 0; b < 64; b++) rk[r-1][b] = k[kw-64+b];
            nk = '0;
            for (int b = 0; b < kw; b++) nk[(b + 61) % kw] = k[b];
            nk[kw-4 +: 4] = SBOX[nk[kw-4 +: 4]];
            if (kw == 128) nk[kw-8 +: 4] = SBOX[nk[kw-8 +: 4]];
            for (int j = 0; j < 5; j++) nk[lsb+j] = nk[lsb+j] ^ r[j];
            k = nk;
        end
        s = din;
        if (!dec) begin
            for (int r = 0; r < ROUNDS; r++) begin
                s = s ^ rk[r];
                for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
                t = '0;
                for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (16 * b) % 63] = s[b];
                s = t;
            end
            s = s ^ rk[ROUNDS];
        end else begin
            s = s ^ rk[ROUNDS];
            for (int r = ROUNDS - 1; r >= 0; r--) begin
                t = '0;
                for (int b = 0; b < 64; b++) t[b] = s[(b == 63) ? 63 : (16 * b) % 63];
                s = '0;
                for (int n = 0; n < 16; n++)
                    for (int v = 0; v < 16; v++)
                        if (SBOX[v] == t[4*n +: 4]) s[4*n +: 4] = 4'(v);
                s = s ^ rk[r];
            end
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per rising edge of ended.
    logic ended_prev [2] = '{1'b0, 1'b0};
    bit   clr_pend   [2] = '{1'b0, 1'b0};
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (clr_pend[d]) begin
                clr_pend[d] = 1'b0;
                chk("ended_one_clock", 64'(ended_s[d]), 64'd0);
                chk("ready_drop_relaunch", 64'(ready_s[d]), 64'd0);
            end
            if (ended_s[d] === 1'b1 && ended_prev[d] !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: dut %0d produced %h, expected no result", d, out_s[d]);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_dut"}, 64'(d), 64'(e.d));
                    chk({e.name, "_out"}, out_s[d], e.exp);
                    chk({e.name, "_latency"}, 64'(cyc), 64'(e.end_cyc));
                    chk({e.name, "_ready"}, 64'(ready_s[d]), 64'd1);
                    clr_pend[d] = e.held;
                end
            end
            ended_prev[d] = ended_s[d];
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int d, input bit dec, input logic [127:0] key,
                         input logic [63:0] din, input logic [63:0] exp, input bit held,
                         input string name);
        int n = 0;
        while (ready_s[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready_s[d] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_wait_ready: ready=%b after %0d cycles, expected 1", name, ready_s[d], n);
            return;
        end
        start_s[d] = 1'b1;
        dec_s[d]   = dec;
        key_s[d]   = key;
        pt_s[d]    = din;
        sb.push_back('{d, exp, cyc + 1 + (dec ? 2 * ROUNDS : ROUNDS), held, name});
        @(negedge clk);
        if (!held) start_s[d] = 1'b0;
        dec_s[d] = 1'($urandom);
        key_s[d] = {$urandom, $urandom, $urandom, $urandom};
        pt_s[d]  = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] k;
        logic [63:0]  p, c;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            dec_s[d]   = 1'b0;
            key_s[d]   = '0;
            pt_s[d]    = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_out", out_s[d], 64'd0);
            chk("reset_ended", 64'(ended_s[d]), 64'd0);
            chk("reset_ready", 64'(ready_s[d]), 64'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vectors, 80-bit key.
        issue(0, 1'b0, '0, '0, 64'h5579C1387B228445, 1'b0, "enc80_zero");
        issue(0, 1'b0, K80_ONES, ONES, 64'h3333DCD3213210D2, 1'b0, "enc80_ones");
        issue(0, 1'b1, K80_ONES, 64'h3333DCD3213210D2, ONES, 1'b0, "dec80_ones");
        issue(0, 1'b0, '0, ONES, 64'hA112FFC72F68417B, 1'b0, "enc80_k0_pf");

        // Start while busy must be ignored.
        repeat (8) @(negedge clk);
        start_s[0] = 1'b1;
        dec_s[0]   = 1'b1;
        key_s[0]   = {$urandom, $urandom, $urandom, $urandom};
        pt_s[0]    = {$urandom, $urandom};
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("busy_start_ignored_ready", 64'(ready_s[0]), 64'd0);
        drain();

        // Reset part way through a decrypt aborts it.
        issue(0, 1'b1, K80_ONES, 64'h3333DCD3213210D2, ONES, 1'b0, "dec80_aborted");
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        chk("abort_out", out_s[0], 64'd0);
        chk("abort_ended", 64'(ended_s[0]), 64'd0);
        chk("abort_ready", 64'(ready_s[0]), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        issue(0, 1'b0, '0, '0, 64'h5579C1387B228445, 1'b0, "enc80_after_rst");
        drain();

        // start held high: back-to-back relaunches.
        for (int i = 0; i < 4; i++)
            issue(0, 1'b0, '0, (i % 2) ? ONES : 64'd0,
                  (i % 2) ? 64'hA112FFC72F68417B : 64'h5579C1387B228445, i < 3, "hold80");
        drain();

        // Random round trips against the reference model.
        for (int i = 0; i < 20; i++) begin
            k = {48'h0, $urandom, $urandom, 16'($urandom)};
            p = {$urandom, $urandom};
            c = ref_cipher(k, 80, p, 1'b0);
            issue(0, 1'b0, k, p, c, 1'b0, "rnd_enc80");
            issue(0, 1'b1, k, c, ref_cipher(k, 80, c, 1'b1), 1'b0, "rnd_dec80");
        end
        drain();
        for (int i = 0; i < 200; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom};
            c = ref_cipher(k, 128, p, 1'b0);
            issue(1, 1'b0, k, p, c, 1'b0, "rnd_enc128");
            issue(1, 1'b1, k, c, ref_cipher(k, 128, c, 1'b1), 1'b0, "rnd_dec128");
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/present_core.md
Name: present_core

Overview:
- Parametrised successor to the fixed PRESENT-80 encrypt-only engine.
- Iterative PRESENT block cipher core, one round per clock.
- Supports 80-bit or 128-bit keys (compile-time) and encrypt or decrypt (per operation).
- Sits between the key/data load logic and the output register bank; the start/ended handshake is kept so existing top-level sequencing is reused.

Parameters:
- KEY_W, 80, key length; legal values 80 or 128, anything else is an elaboration error.
- ROUNDS, 31, number of full rounds; legal range 1..31. The round counter is 5 bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin an operation; sampled only when ready=1.
- decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with start.
- master_key  input  KEY_W  cipher key; sampled with start.
- plain_text  input  64  data in (plaintext or ciphertext); sampled with start.
- out  output  64  result, registered.
- ended  output  1  result valid (level).
- ready  output  1  core idle, start accepted.

Behaviour:
- One clock and a synchronous active-high reset; all state updates on the rising edge of clk.
- Reset: state IDLE, out=0, ended=0, ready=1, round counter rc=0, internal state and key registers = 0. Reset mid-operation aborts the operation; nothing else is emitted.
- FSM states: IDLE, KEYGEN, ENC, DEC.
- IDLE with start=1:
  - latch plain_text into the state register and master_key into the key register;
  - set rc=1, ended=0, ready=0;
  - go to ENC if decrypt=0, else KEYGEN.
- IDLE with start=0: hold; out and ended keep their last values.
- Key register update, 80-bit:
  - rotate left 61;
  - S-box on bits [79:76];
  - XOR rc into bits [19:15].
- Key register update, 128-bit:
  - rotate left 61;
  - S-box on bits [127:124] and [123:120];
  - XOR rc into bits [66:62].
- Round key = key register bits [KEY_W-1 : KEY_W-64].
- ENC, one cycle per round:
  - state <= P(S(state ^ roundkey)); key <= update(key, rc); rc <= rc+1.
  - On the cycle with rc==ROUNDS: out <= P(S(state ^ roundkey)) ^ roundkey_of(update(key, rc)); ended <= 1; ready <= 1; go to IDLE.
  - Encrypt latency: ended is high ROUNDS clocks after the start edge (31 by default).
- KEYGEN:
  - key <= update(key, rc); rc++.
  - When rc==ROUNDS: rc <= ROUNDS (no increment); state <= state ^ roundkey_of(update(key, ROUNDS)); go to DEC.
- DEC, one cycle per round:
  - key <= inverse_update(key, rc), where inverse_update = XOR rc into the same bits, inverse S-box on the top nibble(s), rotate right 61.
  - state <= invS(invP(state)) ^ roundkey_of(inverse_update(key, rc)); rc--.
  - On the cycle with rc==1: out <= that value; ended <= 1; ready <= 1; go to IDLE.
  - Decrypt latency: 2*ROUNDS clocks (62 by default).
- Handshake:
  - start while ready=0 is ignored; inputs may change freely while busy.
  - ended stays high until the next accepted start (cleared on that edge) or reset.
  - start held high continuously re-launches on the cycle after ended rises, with new inputs.
- S-box: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- pLayer: bit i moves to (16*i) mod 63 for i<63; bit 63 stays at 63. The inverse functions are used in DEC.

Test Plan:
- KEY_W=80, encrypt, key 0, pt 0000000000000000 -> out 5579C1387B228445, ended rises 31 clocks after start, ready=1 at the same time.
- KEY_W=80, encrypt, key FFFFFFFFFFFFFFFFFFFF, pt FFFFFFFFFFFFFFFF -> 3333DCD3213210D2. Then decrypt 3333DCD3213210D2 with the same key -> FFFFFFFFFFFFFFFF after 62 clocks.
- KEY_W=80, encrypt, key 0, pt FFFFFFFFFFFFFFFF -> A112FFC72F68417B. Pulse start again while ready=0 mid-run -> ignored; result unchanged.
- KEY_W=128, 200 random key/plaintext pairs: encrypt then decrypt -> original plaintext returned; compared against a bench reference model for both directions.
- Assert rst at cycle 10 of a decrypt -> next edge: out=0, ended=0, ready=1. A fresh encrypt (key 0, pt 0) then completes correctly with 5579C1387B228445.
- Hold start=1 with pt 0/FFFF..FF alternating each accept -> back-to-back results with ended staying high between ops for exactly one clock, and ready re-asserting each time.
